pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Sequences the pixel-clock PLL (50 MHz refclk in, 40 MHz pixel clock out) and generates the design's system reset from its lock status. It pulses the PLL reset and waits for lock with a timeout and bounded retries. It requires lock to stay stable before releasing system reset, and restarts the PLL on lock loss or on request. It runs entirely in the free-running refclk domain. Consumers in the pixel domain resynchronize sys_rst_n themselves.

Parameters:
RST_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 50000, refclk cycles to wait for lock per attempt (1 ms @ 50 MHz)
STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release
MAX_RETRIES, 7, timed-out attempts tolerated before FAULT (<=255)
CNT_W, $clog2(max(RST_CYCLES,LOCK_TIMEOUT,STABLE_CYCLES))+1, shared cycle-counter width (derived)

Ports:
refclk  in  1  free-running 50 MHz reference clock; clocks the whole block
rst_n  in  1  asynchronous, active-low reset
pll_locked  in  1  PLL locked output, asynchronous to refclk
relock_req  in  1  single-cycle request to restart the PLL sequence (mode change or fault recovery)
pll_rst  out  1  active-high reset to the PLL
sys_rst_n  out  1  active-low system reset; high only while in RUN
ready  out  1  high in RUN
fault  out  1  high in FAULT
retry_cnt  out  8  timed-out attempts in the current sequence
loss_cnt  out  8  lock losses seen in RUN; saturates at 255

Behaviour:
- Reset (rst_n low, async): state=HOLD, counter=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, loss_cnt=0, sync flops=0.
- pll_locked passes through a 2-FF synchronizer, giving locked_s. All decisions use locked_s.
- All outputs are registered and decoded from next_state. An output changes on the same edge as the state change.
- The single counter clears on every state entry and increments each cycle while in HOLD, WAIT_LOCK or STABLE.
- HOLD: pll_rst=1. When counter==RST_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK: pll_rst=0.
  - If locked_s=1, go to STABLE.
  - Else, when counter==LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRIES, go to FAULT;
    - else retry_cnt++ and go to HOLD.
  - If locked_s=1 on the timeout cycle, lock wins.
- STABLE: if locked_s=0, go to WAIT_LOCK; the timeout restarts and retry_cnt is unchanged. Else, when counter==STABLE_CYCLES-1, go to RUN.
- RUN: sys_rst_n=1, ready=1, retry_cnt cleared on entry.
  - If locked_s=0, go to HOLD and increment loss_cnt (saturating).
  - Else if relock_req=1, go to HOLD without incrementing loss_cnt.
  - If both occur in the same cycle, it is counted as a loss.
- FAULT: pll_rst=1, fault=1, sys_rst_n=0. The PLL is held in reset indefinitely. relock_req=1 goes to HOLD and clears retry_cnt and fault.
- relock_req in HOLD, WAIT_LOCK or STABLE restarts HOLD with counter=0; retry_cnt is unchanged.
- Latency:
  - pll_locked falling edge in RUN to sys_rst_n low: 3 refclk edges (2 synchronizer + 1 state/output register).
  - pll_locked rising edge in WAIT_LOCK to sys_rst_n high: 2+1+STABLE_CYCLES edges.
- A glitch on pll_locked shorter than one refclk cycle may be missed; this is acceptable. A glitch that is seen is handled by the rules above.
- rst_n asserted mid-sequence: immediate return to reset values, and pll_rst goes high asynchronously.
- Counters never wrap: the cycle counter is bounded by state exit, and loss_cnt saturates.

Decomposition:
- Package pll_seq_pkg: state enum (HOLD, WAIT_LOCK, STABLE, RUN, FAULT), default timing constants, and a clog2 helper.
- Sub-module sync_2ff (1-bit, async active-low reset to 0) for pll_locked. It is reusable for the VGA mode-select inputs.

Test Plan:
(Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.)
1. Nominal bring-up: release rst_n, raise pll_locked 10 cycles after pll_rst falls → pll_rst high exactly 4 cycles; sys_rst_n and ready rise 2+1+8 edges after pll_locked rises; retry_cnt=0.
2. Timeout and retry: keep pll_locked=0 → pll_rst re-pulses for 4 cycles after each 20-cycle wait; retry_cnt goes 1, 2; on the third timeout, fault=1, pll_rst=1, sys_rst_n=0. Then pulse relock_req → fault=0, retry_cnt=0, HOLD restarts.
3. Stability glitch: in STABLE, drop pll_locked for 3 cycles at counter=5 → return to WAIT_LOCK; sys_rst_n stays 0; a full 8-cycle stable window is required again.
4. Loss in RUN: drop pll_locked → sys_rst_n=0 and ready=0 three edges later; loss_cnt=1; pll_rst high 4 cycles; recovery repeats scenario 1.
5. Simultaneous relock_req and lock loss in RUN → single HOLD entry, loss_cnt increments by exactly 1. relock_req alone → loss_cnt unchanged.
6. Async reset asserted mid-STABLE (counter=3) → pll_rst=1 and sys_rst_n=0 immediately with no clock edge; all counters 0; sequence restarts cleanly after release.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - states, default timing and width helpers for the PLL reset sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } seq_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 7;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock wait with retries, stable-lock check and system reset release
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_MAX    = 8'(MAX_RETRIES);

    logic             locked_s;
    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             restart;

    sync_2ff u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        restart = 1'b0;
        case (state_q)
            HOLD: begin
                if (relock_req)               restart = 1'b1;
                else if (cnt_q == RST_LAST)   state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // lock is checked before the timeout so a lock on the last cycle wins
                if (relock_req)               state_d = HOLD;
                else if (locked_s)            state_d = STABLE;
                else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 8'd1;
                        state_d = HOLD;
                    end
                end
            end
            STABLE: begin
                if (relock_req)               state_d = HOLD;
                else if (!locked_s)           state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = HOLD;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (relock_req) begin
                    state_d = HOLD;
                end
            end
            FAULT: begin
                if (relock_req) begin
                    state_d = HOLD;
                    retry_d = '0;
                end
            end
            default: state_d = HOLD;
        endcase

        if (restart || (state_d != state_q))
            cnt_d = '0;
        else if (state_q inside {HOLD, WAIT_LOCK, STABLE})
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = cnt_q;
    end

    // outputs decode next_state so they switch on the same edge as the state
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst   <= (state_d == HOLD) || (state_d == FAULT);
            sys_rst_n <= (state_d == RUN);
            ready     <= (state_d == RUN);
            fault     <= (state_d == FAULT);
        end
    end

    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    pll_reset_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    typedef struct {
        string       tag;
        int          cyc;
        logic [19:0] vec;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc;
    logic [19:0] prev_obs;
    logic        e_pll, e_sys, e_rdy, e_flt;
    logic [7:0]  e_retry, e_loss;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic exp_at(input string tag, input int c);
        exp_t e;
        e.tag = tag;
        e.cyc = c;
        e.vec = {e_pll, e_sys, e_rdy, e_flt, e_retry, e_loss};
        sb_q.push_back(e);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) @(negedge refclk);
    endtask

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // every output change must match the next queued expectation, value and cycle
    always @(negedge refclk) begin
        logic [19:0] obs;
        obs = {pll_rst, sys_rst_n, ready, fault, retry_cnt, loss_cnt};
        if (rst_n && (obs !== prev_obs)) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_change", 32'(obs), 32'(prev_obs));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val(e.tag, 32'(obs), 32'(e.vec));
                check_val({e.tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
            end
        end
        prev_obs = obs;
    end

    initial begin
        rst_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
        e_pll = 1'b1; e_sys = 1'b0; e_rdy = 1'b0; e_flt = 1'b0; e_retry = 8'd0; e_loss = 8'd0;
        repeat (3) @(negedge refclk);
        check_val("rst_pll_rst",   32'(pll_rst),   32'd1);
        check_val("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check_val("rst_ready",     32'(ready),     32'd0);
        check_val("rst_fault",     32'(fault),     32'd0);
        check_val("rst_retry",     32'(retry_cnt), 32'd0);
        check_val("rst_loss",      32'(loss_cnt),  32'd0);
        rst_n = 1'b1;

        // nominal bring-up
        e_pll = 1'b0; exp_at("s1_pll_fall", 4);
        go_to(14); pll_locked = 1'b1;
        e_sys = 1'b1; e_rdy = 1'b1; exp_at("s1_run", 25);

        // lock loss in RUN and recovery
        go_to(30); pll_locked = 1'b0;
        e_pll = 1'b1; e_sys = 1'b0; e_rdy = 1'b0; e_loss = 8'd1; exp_at("s4_loss", 33);
        e_pll = 1'b0; exp_at("s4_pll_fall", 37);
        go_to(40); pll_locked = 1'b1;
        e_sys = 1'b1; e_rdy = 1'b1; exp_at("s4_run", 51);

        // relock_req coinciding with loss, then relock_req alone
        go_to(55); pll_locked = 1'b0;
        e_pll = 1'b1; e_sys = 1'b0; e_rdy = 1'b0; e_loss = 8'd2; exp_at("s5_both", 58);
        go_to(57); relock_req = 1'b1;
        go_to(58); relock_req = 1'b0;
        e_pll = 1'b0; exp_at("s5_pll_fall", 62);
        go_to(65); pll_locked = 1'b1;
        e_sys = 1'b1; e_rdy = 1'b1; exp_at("s5_run", 76);
        go_to(80); relock_req = 1'b1;
        e_pll = 1'b1; e_sys = 1'b0; e_rdy = 1'b0; exp_at("s5_relock", 81);
        go_to(81); relock_req = 1'b0;
        e_pll = 1'b0; exp_at("s5_relock_fall", 85);
        e_sys = 1'b1; e_rdy = 1'b1; exp_at("s5_relock_run", 94);

        // glitch in STABLE at counter 5
        go_to(96); relock_req = 1'b1;
        e_pll = 1'b1; e_sys = 1'b0; e_rdy = 1'b0; exp_at("s3_hold", 97);
        go_to(97); relock_req = 1'b0;
        e_pll = 1'b0; exp_at("s3_pll_fall", 101);
        go_to(107); pll_locked = 1'b0;
        go_to(110); pll_locked = 1'b1;
        e_sys = 1'b1; e_rdy = 1'b1; exp_at("s3_run", 121);

        // timeouts, retries, FAULT and recovery
        go_to(125); pll_locked = 1'b0;
        e_pll = 1'b1; e_sys = 1'b0; e_rdy = 1'b0; e_loss = 8'd3; exp_at("s2_loss", 128);
        e_pll = 1'b0; exp_at("s2_wait0", 132);
        e_pll = 1'b1; e_retry = 8'd1; exp_at("s2_retry1", 152);
        e_pll = 1'b0; exp_at("s2_wait1", 156);
        e_pll = 1'b1; e_retry = 8'd2; exp_at("s2_retry2", 176);
        e_pll = 1'b0; exp_at("s2_wait2", 180);
        e_pll = 1'b1; e_flt = 1'b1; exp_at("s2_fault", 200);
        go_to(205); relock_req = 1'b1;
        e_flt = 1'b0; e_retry = 8'd0; exp_at("s2_recover", 206);
        go_to(206); relock_req = 1'b0;
        e_pll = 1'b0; exp_at("s2_pll_fall", 210);

        // async reset mid-STABLE
        go_to(212); pll_locked = 1'b1;
        go_to(218);
        check_val("sb_pre_reset", 32'(sb_q.size()), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_val("s6_pll_rst",   32'(pll_rst),   32'd1);
        check_val("s6_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check_val("s6_ready",     32'(ready),     32'd0);
        check_val("s6_fault",     32'(fault),     32'd0);
        check_val("s6_retry",     32'(retry_cnt), 32'd0);
        check_val("s6_loss",      32'(loss_cnt),  32'd0);
        e_pll = 1'b1; e_sys = 1'b0; e_rdy = 1'b0; e_flt = 1'b0; e_retry = 8'd0; e_loss = 8'd0;
        repeat (2) @(negedge refclk);
        rst_n = 1'b1;
        e_pll = 1'b0; exp_at("s6_pll_fall", 4);
        e_sys = 1'b1; e_rdy = 1'b1; exp_at("s6_run", 13);
        go_to(20);
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
